typecm_tx_sched: RTL and testbench



---
 rtl/typecm_tx_sched.sv | 176 +++++++++++++++++
 tb/tb_typecm_tx_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/typecm_tx_sched.sv
// typecm_tx_sched
// Shares one typecm_tx packet transmitter among NREQ requesters. Handshake
// packets (ACK/NAK/STALL) go ahead of data packets. Requesters of the same
// class are served round-robin. The winner's fields are latched onto the
// transmitter inputs, the fs/fd handshake is run, and a one-cycle done or err
// pulse is returned to that requester.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req             per-requester level request, held until done/err
//   req_btype       packed packet types, requester i at [4i+3:4i]
//   req_didx        packed device index fields
//   req_freq        packed frequency/parameter fields
//   req_ddidx       packed data-device index fields
//   done            one-cycle pulse per requester: packet sent
//   err             one-cycle pulse per requester: bad btype or timeout
//   busy            high whenever the scheduler is not idle
//   gnt_idx         index of the current/last granted requester
//   fs              start strobe to typecm_tx (high throughout SEND)
//   fd              done strobe from typecm_tx
//   btype, didx, freq, ddidx   latched packet fields to typecm_tx
module typecm_tx_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_btype,
  input  logic [4*NREQ-1:0] req_didx,
  input  logic [4*NREQ-1:0] req_freq,
  input  logic [4*NREQ-1:0] req_ddidx,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic              busy,
  output logic [2:0]        gnt_idx,
  output logic              fs,
  input  logic              fd,
  output logic [3:0]        btype,
  output logic [3:0]        didx,
  output logic [3:0]        freq,
  output logic [3:0]        ddidx
);

  typedef enum logic [2:0] {IDLE, ARB, LOAD, SEND, DONE, GAP} state_t;

  localparam logic [2:0]    LAST_IDX = 3'(NREQ - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [2:0]      rr_ptr;
  logic [TW-1:0]   tmo_cnt;
  logic            fail_flag;

  logic [NREQ-1:0] hs_mask;
  logic [NREQ-1:0] cand;
  logic            win_found;
  logic [2:0]      win_idx;
  logic [3:0]      win_btype;

  function automatic logic is_hs(input logic [3:0] t);
    return t inside {4'h1, 4'h2, 4'h3};
  endfunction

  function automatic logic is_valid(input logic [3:0] t);
    return is_hs(t) || (t inside {[4'h5:4'hA], 4'hC, 4'hD, 4'hE});
  endfunction

  // Arbitration: restrict to handshake requesters when any exist, then take
  // the first candidate at or above rr_ptr; if none, the lowest candidate
  // below it, which is the wrapped continuation of the same search.
  always_comb begin
    hs_mask = '0;
    for (int i = 0; i < NREQ; i++)
      hs_mask[i] = req[i] & is_hs(req_btype[4*i +: 4]);
    cand      = (|hs_mask) ? hs_mask : req;
    win_found = 1'b0;
    win_idx   = '0;
    win_btype = '0;
    for (int i = 0; i < NREQ; i++)
      if (!win_found && cand[i] && (3'(i) >= rr_ptr)) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
      end
    for (int i = 0; i < NREQ; i++)
      if (!win_found && cand[i]) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
      end
    for (int i = 0; i < NREQ; i++)
      if (3'(i) == win_idx)
        win_btype = req_btype[4*i +: 4];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the state-decoded outputs. fs is a pure decode of SEND so
  // an asynchronous reset drops it immediately.
  always_comb begin
    state_nxt = state;
    fs        = 1'b0;
    busy      = (state != IDLE);
    done      = '0;
    err       = '0;
    case (state)
      IDLE: if (|req) state_nxt = ARB;
      // A request withdrawn before arbitration leaves nothing to serve.
      ARB: begin
        if (!win_found)                state_nxt = IDLE;
        else if (!is_valid(win_btype)) state_nxt = DONE;
        else                           state_nxt = LOAD;
      end
      LOAD: state_nxt = SEND;
      // fd takes precedence over a timeout expiring in the same cycle.
      SEND: begin
        fs = 1'b1;
        if (fd || tmo_cnt == TMO_LAST) state_nxt = DONE;
      end
      DONE: begin
        for (int i = 0; i < NREQ; i++)
          if (3'(i) == gnt_idx) begin
            done[i] = ~fail_flag;
            err[i]  = fail_flag;
          end
        state_nxt = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, outcome flag, timeout counter, round-robin pointer and the frozen
  // packet fields. Fields only change in LOAD, so req_* may move at any other
  // time without disturbing a packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_idx   <= '0;
      rr_ptr    <= '0;
      tmo_cnt   <= '0;
      fail_flag <= 1'b0;
      btype     <= '0;
      didx      <= '0;
      freq      <= '0;
      ddidx     <= '0;
    end else begin
      case (state)
        ARB: if (win_found) begin
          gnt_idx   <= win_idx;
          fail_flag <= ~is_valid(win_btype);
        end
        LOAD: begin
          for (int i = 0; i < NREQ; i++)
            if (3'(i) == gnt_idx) begin
              btype <= req_btype[4*i +: 4];
              didx  <= req_didx[4*i +: 4];
              freq  <= req_freq[4*i +: 4];
              ddidx <= req_ddidx[4*i +: 4];
            end
          tmo_cnt   <= '0;
          fail_flag <= 1'b0;
        end
        SEND: if (!fd) begin
          if (tmo_cnt == TMO_LAST) fail_flag <= 1'b1;
          else                     tmo_cnt   <= tmo_cnt + TW'(1);
        end
        DONE: rr_ptr <= (gnt_idx == LAST_IDX) ? 3'd0 : gnt_idx + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_typecm_tx_sched.sv
// tb_typecm_tx_sched
// Scoreboard bench for typecm_tx_sched (NREQ=4, TIMEOUT=16). Each request
// pushes its expected grant, fields, outcome and fs length. A negedge monitor
// pops an entry on every done/err pulse and compares it. A small typecm_tx
// responder returns fd a programmable number of cycles into SEND.
module tb_typecm_tx_sched;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;
  localparam int TW      = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [4*NREQ-1:0] req_btype = '0;
  logic [4*NREQ-1:0] req_didx  = '0;
  logic [4*NREQ-1:0] req_freq  = '0;
  logic [4*NREQ-1:0] req_ddidx = '0;
  logic [NREQ-1:0]   done, err;
  logic              busy, fs, fd;
  logic [2:0]        gnt_idx;
  logic [3:0]        btype, didx, freq, ddidx;

  logic fd_force = 1'b0;
  logic fd_auto  = 1'b0;
  int   fd_delay = -1;
  assign fd = fd_force | fd_auto;

  typedef struct {
    int         idx;
    logic [3:0] bt, di, fr, dd;
    bit         is_err;
    int         fs_len;
  } exp_t;

  exp_t            sb[$];
  exp_t            head;
  logic [NREQ-1:0] exp_oh;
  int              pending_cnt[NREQ];
  int              errors = 0;
  int              checks = 0;
  int              fs_run = 0;
  int              low_run = 0;
  bit              fs_prev = 1'b0;
  bit              had_pkt = 1'b0;

  typecm_tx_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_btype(req_btype), .req_didx(req_didx),
    .req_freq(req_freq), .req_ddidx(req_ddidx),
    .done(done), .err(err), .busy(busy), .gnt_idx(gnt_idx),
    .fs(fs), .fd(fd),
    .btype(btype), .didx(didx), .freq(freq), .ddidx(ddidx)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Global watchdog so a stuck design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Raise requester i with the given fields and queue what it should produce.
  task automatic applyStimulus(input int i, input logic [3:0] bt,
                               input logic [3:0] di, input logic [3:0] fr,
                               input logic [3:0] dd, input bit is_err,
                               input int fs_len);
    exp_t e;
    req_btype[4*i +: 4] = bt;
    req_didx[4*i +: 4]  = di;
    req_freq[4*i +: 4]  = fr;
    req_ddidx[4*i +: 4] = dd;
    req[i]              = 1'b1;
    pending_cnt[i]++;
    e.idx = i; e.bt = bt; e.di = di; e.fr = fr; e.dd = dd;
    e.is_err = is_err; e.fs_len = fs_len;
    sb.push_back(e);
  endtask

  // A requester drops req in the pulse cycle once all its packets are served.
  task automatic serviceDrops();
    for (int i = 0; i < NREQ; i++)
      if (done[i] || err[i]) begin
        pending_cnt[i]--;
        if (pending_cnt[i] <= 0) begin
          pending_cnt[i] = 0;
          req[i] = 1'b0;
        end
      end
  endtask

  // Count negedges from now until fs (or any err) is seen.
  task automatic measureLatency(input string tag, input bit want_err,
                                input int expected);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk); #1;
      n++;
      serviceDrops();
      seen = want_err ? (|err) : fs;
    end
    checkOutput(tag, 32'(n), 32'(expected));
  endtask

  // Wait until the scoreboard empties, then let the scheduler settle in IDLE.
  task automatic waitDrain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      serviceDrops();
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
      req = '0;
      for (int i = 0; i < NREQ; i++) pending_cnt[i] = 0;
    end
    repeat (4) begin @(negedge clk); #1; end
  endtask

  // Monitor and fd responder: checks grant and frozen fields during SEND, the
  // fs-low gap between packets, and pops the scoreboard on every pulse.
  always @(negedge clk) begin
    if (rst) begin
      fs_run = 0; low_run = 0; fs_prev = 1'b0; had_pkt = 1'b0; fd_auto = 1'b0;
    end else begin
      if (fs) begin
        if (sb.size() == 0) checkOutput("unexpected_fs", 32'(fs), 32'd0);
        else begin
          if (!fs_prev) begin
            checkOutput("gnt_idx", 32'(gnt_idx), 32'(sb[0].idx));
            if (had_pkt) checkOutput("fs_gap_ge3", 32'(low_run >= 3), 32'd1);
          end
          checkOutput("fields", 32'({btype, didx, freq, ddidx}),
                      32'({sb[0].bt, sb[0].di, sb[0].fr, sb[0].dd}));
        end
        fs_run++;
        low_run = 0;
        had_pkt = 1'b1;
      end else begin
        low_run++;
      end
      fd_auto = fs && (fd_delay >= 0) && (fs_run == fd_delay + 1);
      if (|done || |err) begin
        if (sb.size() == 0) checkOutput("unexpected_pulse", 32'({done, err}), 32'd0);
        else begin
          head   = sb.pop_front();
          exp_oh = NREQ'(1) << head.idx;
          checkOutput("done", 32'(done), head.is_err ? 32'd0 : 32'(exp_oh));
          checkOutput("err", 32'(err), head.is_err ? 32'(exp_oh) : 32'd0);
          checkOutput("pulse_gnt", 32'(gnt_idx), 32'(head.idx));
          checkOutput("fs_cycles", 32'(fs_run), 32'(head.fs_len));
        end
        fs_run = 0;
      end
      fs_prev = fs;
    end
  end

  // Main sequence of directed scenarios.
  initial begin
    for (int i = 0; i < NREQ; i++) pending_cnt[i] = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_fs", 32'(fs), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_fields", 32'({btype, didx, freq, ddidx}), 32'd0);
    checkOutput("rst_pulses", 32'({done, err}), 32'd0);
    checkOutput("rst_gnt", 32'(gnt_idx), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk); #1;

    $display("[TB] single request on requester 2");
    fd_delay = 4;
    applyStimulus(2, 4'h5, 4'h5, 4'h3, 4'hA, 1'b0, 5);
    measureLatency("latency_single", 1'b0, 3);
    req_btype[11:8] = 4'h6;
    req_didx[11:8]  = 4'h9;
    waitDrain(100);

    $display("[TB] handshake priority over data");
    fd_delay = 2;
    applyStimulus(3, 4'h2, 4'h1, 4'h2, 4'h3, 1'b0, 3);
    applyStimulus(0, 4'hD, 4'h7, 4'h8, 4'h9, 1'b0, 3);
    waitDrain(200);

    $display("[TB] invalid btype");
    applyStimulus(1, 4'hB, 4'h4, 4'h4, 4'h4, 1'b1, 0);
    measureLatency("latency_err", 1'b1, 2);
    waitDrain(50);

    $display("[TB] timeout with fd held low");
    fd_delay = -1;
    applyStimulus(1, 4'h7, 4'h2, 4'h4, 4'h6, 1'b1, TIMEOUT);
    waitDrain(200);

    $display("[TB] fd coinciding with timeout");
    fd_delay = TIMEOUT - 1;
    applyStimulus(1, 4'hE, 4'h3, 4'h5, 4'h7, 1'b0, TIMEOUT);
    waitDrain(200);

    $display("[TB] fd while idle");
    fd_force = 1'b1;
    repeat (2) begin @(negedge clk); #1; end
    fd_force = 1'b0;
    checkOutput("idle_fd_busy", 32'(busy), 32'd0);
    checkOutput("idle_fd_fs", 32'(fs), 32'd0);
    repeat (3) begin @(negedge clk); #1; end

    $display("[TB] reset during SEND");
    fd_delay = -1;
    applyStimulus(2, 4'h8, 4'h1, 4'h1, 4'h1, 1'b0, 0);
    measureLatency("latency_pre_rst", 1'b0, 3);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_fs", 32'(fs), 32'd0);
    checkOutput("rst_mid_btype", 32'(btype), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_pulses", 32'({done, err}), 32'd0);
    sb.delete();
    pending_cnt[2] = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    fd_delay = 3;
    applyStimulus(2, 4'h8, 4'h1, 4'h1, 4'h1, 1'b0, 4);
    measureLatency("latency_post_rst", 1'b0, 3);
    waitDrain(100);

    $display("[TB] round-robin among four data requesters");
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    fd_delay = 1;
    applyStimulus(0, 4'h5, 4'h0, 4'h0, 4'h1, 1'b0, 2);
    applyStimulus(1, 4'h5, 4'h1, 4'h0, 4'h2, 1'b0, 2);
    applyStimulus(2, 4'h5, 4'h2, 4'h0, 4'h3, 1'b0, 2);
    applyStimulus(3, 4'h5, 4'h3, 4'h0, 4'h4, 1'b0, 2);
    applyStimulus(0, 4'h5, 4'h0, 4'h0, 4'h1, 1'b0, 2);
    applyStimulus(1, 4'h5, 4'h1, 4'h0, 4'h2, 1'b0, 2);
    waitDrain(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
